// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants for the interrupt controller.
//   - register addresses (MASK/EDGE/PEND/STATUS)
//   - FSM state encoding
//   - STATUS register field positions
//   - idx_w(): bits needed to index n items (minimum 1)
package int_ctrl_pkg;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_EDGE   = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  localparam int unsigned STS_SEL_LSB   = 0;
  localparam int unsigned STS_SEL_W     = 3;
  localparam int unsigned STS_STATE_LSB = 4;
  localparam int unsigned STS_ANY_BIT   = 6;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// int_prio_enc: highest-index priority encoder.
//   req_i   : request vector
//   idx_o   : index of the highest set bit of req_i (0 when none)
//   valid_o : at least one bit of req_i is set
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N  = 6,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o = '0;
    // Ascending scan: the last hit is the highest index.
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i]) idx_o = IW'(i);
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller feeding the CP0 HWInt input.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   src_irq   : raw device interrupt lines (synchronous to clk)
//   we/addr/wdata/rdata : register port (0=MASK 1=EDGE 2=PEND 3=STATUS)
//   irq_taken : exception entry pulse from CP0
//   eret      : handler exit pulse
//   hwint     : one-hot request to CP0 (at most one bit set)
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NSRC    = 6,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic            irq_taken,
  input  logic            eret,
  output logic [NSRC-1:0] hwint
);

  localparam int unsigned SELW = idx_w(NSRC);
  localparam int unsigned CW   = idx_w(HOLDOFF + 1);

  logic [NSRC-1:0] src_q, src_p, mask_q, emode_q, pend_q, pend_d;
  logic [NSRC-1:0] hwint_q, hwint_d, active, rise, w1c;
  logic [1:0]      hist_q;
  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d, enc_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            enc_valid, sel_live;
  logic            wr_mask, wr_emode, wr_pend;
  logic            wdata_unused;

  assign wdata_unused = ^wdata[31:NSRC];

  assign wr_mask  = we && (addr == ADDR_MASK);
  assign wr_emode = we && (addr == ADDR_EDGE);
  assign wr_pend  = we && (addr == ADDR_PEND);

  // hist_q[1] marks src_p as holding post-reset samples; until then a line
  // that was already high would look like a rising edge.
  assign rise   = hist_q[1] ? (src_q & ~src_p) : '0;
  assign w1c    = wr_pend ? wdata[NSRC-1:0] : '0;
  // Edge bits: W1C then set (set wins). Level bits: follow src_q.
  assign pend_d = (emode_q & ((pend_q & ~w1c) | rise)) | (~emode_q & src_q);

  assign active   = pend_q & mask_q;
  assign sel_live = active[sel_q];

  int_prio_enc #(
    .N  (NSRC),
    .IW (SELW)
  ) u_prio (
    .req_i   (active),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          sel_d   = enc_idx;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (irq_taken)     state_d = ST_SERVICE;
        else if (!sel_live) state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (eret) begin
          if (HOLDOFF == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            cnt_d   = CW'(HOLDOFF);
          end
        end
      end
      ST_HOLDOFF: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Output is registered from current state so nothing combinational
    // from src_irq/we/irq_taken reaches hwint.
    hwint_d = '0;
    if ((state_q == ST_ASSERT || state_q == ST_SERVICE) && sel_live)
      hwint_d[sel_q] = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_MASK: rdata[NSRC-1:0] = mask_q;
      ADDR_EDGE: rdata[NSRC-1:0] = emode_q;
      ADDR_PEND: rdata[NSRC-1:0] = pend_q;
      default: begin
        rdata[STS_SEL_LSB +: STS_SEL_W] = STS_SEL_W'(sel_q);
        rdata[STS_STATE_LSB +: 2]       = state_q;
        rdata[STS_ANY_BIT]              = |active;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q   <= '0;
      src_p   <= '0;
      hist_q  <= '0;
      mask_q  <= '0;
      emode_q <= '0;
      pend_q  <= '0;
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      hwint_q <= '0;
    end else begin
      src_q   <= src_irq;
      src_p   <= src_q;
      hist_q  <= {hist_q[0], 1'b1};
      if (wr_mask)  mask_q  <= wdata[NSRC-1:0];
      if (wr_emode) emode_q <= wdata[NSRC-1:0];
      pend_q  <= pend_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      hwint_q <= hwint_d;
    end
  end

  assign hwint = hwint_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  src_irq = '0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq_taken = 1'b0;
  logic        eret = 1'b0;
  logic [5:0]  hwint;

  always #5 clk = ~clk;

  int_ctrl #(.NSRC(6), .HOLDOFF(2)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq_taken(irq_taken), .eret(eret),
    .hwint(hwint)
  );

  typedef struct {
    string       name;
    bit          is_rd;
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int nchk = 0;
  int npass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        act = sb[i].is_rd ? rdata : {26'd0, hwint};
        nchk++;
        if (act === sb[i].val) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                      sb[i].name, act, sb[i].val, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic exp_hw(input string nm, input logic [5:0] v, input int lat);
    sb.push_back('{name: nm, is_rd: 1'b0, val: {26'd0, v}, due: cyc + lat});
  endtask

  task automatic exp_rd(input string nm, input logic [1:0] a, input logic [31:0] v);
    addr = a;
    sb.push_back('{name: nm, is_rd: 1'b1, val: v, due: cyc});
  endtask

  task automatic service(input logic [5:0] clr);
    irq_taken = 1'b1; step(); irq_taken = 1'b0;
    wr(ADDR_PEND, {26'd0, clr});
    eret = 1'b1; step(); eret = 1'b0;
    step(4);
  endtask

  initial begin
    step(2);
    nchk++;
    if (hwint === 6'h00) npass++;
    else $display("FAIL rst_hwint_direct: got 0x%0h, expected 0x0", hwint);
    exp_hw("rst_hwint", 6'h00, 0);
    exp_rd("rst_status", ADDR_STATUS, 32'h0);
    step();
    reset = 1'b1;
    step(2);

    irq_taken = 1'b1; eret = 1'b1; step(); irq_taken = 1'b0; eret = 1'b0;
    exp_rd("idle_ignore", ADDR_STATUS, 32'h0);
    step();

    wr(ADDR_MASK, 32'h3F);
    wr(ADDR_EDGE, 32'h04);
    src_irq = 6'h04;
    exp_hw("t1_early", 6'h00, 3);
    exp_hw("t1_on", 6'h04, 4);
    step(); src_irq = 6'h00;
    step(3);
    eret = 1'b1; step(); eret = 1'b0;
    exp_rd("t1_status", ADDR_STATUS, 32'h52);
    exp_hw("t1_hold", 6'h04, 0);
    step();
    exp_rd("t1_pend", ADDR_PEND, 32'h04);
    service(6'h04);
    exp_rd("t1_idle_status", ADDR_STATUS, 32'h02);
    exp_hw("t1_off", 6'h00, 0);
    step();

    wr(ADDR_EDGE, 32'h3F);
    src_irq = 6'h12;
    exp_hw("t2_early", 6'h00, 3);
    exp_hw("t2_sel4", 6'h10, 4);
    step(4);
    exp_rd("t2_status_a", ADDR_STATUS, 32'h54);
    irq_taken = 1'b1; step(); irq_taken = 1'b0;
    wr(ADDR_PEND, 32'h10);
    exp_rd("t2_status_s", ADDR_STATUS, 32'h64);
    exp_hw("t2_srv", 6'h10, 0);
    exp_hw("t2_cleared", 6'h00, 1);
    eret = 1'b1; step(); eret = 1'b0;
    exp_hw("t2_holdoff", 6'h00, 3);
    exp_hw("t2_sel1", 6'h02, 4);
    step();
    exp_rd("t2_status_h", ADDR_STATUS, 32'h74);
    step(3);
    src_irq = 6'h00;
    service(6'h02);
    exp_rd("t2_status_end", ADDR_STATUS, 32'h01);
    exp_hw("t2_off", 6'h00, 0);
    step();

    src_irq = 6'h08;
    exp_hw("t3_on", 6'h08, 4);
    step(4);
    wr(ADDR_MASK, 32'h0);
    exp_hw("t3_still", 6'h08, 0);
    exp_hw("t3_masked", 6'h00, 1);
    step();
    exp_rd("t3_status", ADDR_STATUS, 32'h03);
    step();
    exp_rd("t3_pend", ADDR_PEND, 32'h08);
    step();
    wr(ADDR_MASK, 32'h3F);
    exp_hw("t3_gap", 6'h00, 1);
    exp_hw("t3_restored", 6'h08, 2);
    step(2);
    src_irq = 6'h00;
    service(6'h08);

    src_irq = 6'h01;
    step();
    addr = ADDR_PEND; wdata = 32'h1; we = 1'b1;
    step();
    we = 1'b0; src_irq = 6'h00;
    exp_rd("t4_set_wins", ADDR_PEND, 32'h01);
    exp_hw("t4_on", 6'h01, 2);
    step(2);
    service(6'h01);
    exp_rd("t4_w1c", ADDR_PEND, 32'h00);
    step();

    wr(ADDR_EDGE, 32'h1F);
    src_irq = 6'h20;
    exp_hw("t5_early", 6'h00, 3);
    exp_hw("t5_on", 6'h20, 4);
    step(4);
    irq_taken = 1'b1; step(); irq_taken = 1'b0;
    wr(ADDR_PEND, 32'h20);
    exp_rd("t5_level_w1c", ADDR_PEND, 32'h20);
    eret = 1'b1; step(); eret = 1'b0;
    exp_hw("t5_srv", 6'h20, 0);
    exp_hw("t5_holdoff", 6'h00, 1);
    exp_hw("t5_idle", 6'h00, 3);
    exp_hw("t5_reassert", 6'h20, 4);
    step(4);
    src_irq = 6'h00;
    exp_hw("t5_lag", 6'h20, 2);
    exp_hw("t5_drop", 6'h00, 3);
    step(3);

    src_irq = 6'h20;
    step(4);
    exp_hw("t6_pre", 6'h20, 0);
    irq_taken = 1'b1; step(); irq_taken = 1'b0;
    reset = 1'b0;
    #1;
    nchk++;
    if (hwint === 6'h00) npass++;
    else $display("FAIL t6_async_direct: got 0x%0h, expected 0x0", hwint);
    exp_hw("t6_async_drop", 6'h00, 0);
    exp_rd("t6_status_rst", ADDR_STATUS, 32'h0);
    step(2);
    reset = 1'b1;
    wr(ADDR_EDGE, 32'h3F);
    wr(ADDR_MASK, 32'hFFFF_FFFF);
    exp_rd("t6_mask_width", ADDR_MASK, 32'h3F);
    exp_hw("t6_no_edge_a", 6'h00, 2);
    exp_hw("t6_no_edge_b", 6'h00, 5);
    step();
    exp_rd("t6_edge", ADDR_EDGE, 32'h3F);
    step();
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    exp_rd("t6_status_ro", ADDR_STATUS, 32'h0);
    step();
    exp_rd("t6_pend", ADDR_PEND, 32'h0);
    #1;
    nchk++;
    if (rdata === 32'h0) npass++;
    else $display("FAIL t6_pend_direct: got 0x%0h, expected 0x0", rdata);
    src_irq = 6'h00;
    step(2);
    src_irq = 6'h20;
    exp_hw("t6_fresh_early", 6'h00, 3);
    exp_hw("t6_fresh_edge", 6'h20, 4);
    step(6);

    for (int g = 0; g < 20 && sb.size() > 0; g++) step();
    while (sb.size() > 0) begin
      nchk++;
      $display("FAIL %s: never sampled, expected 0x%0h", sb[0].name, sb[0].val);
      sb.delete(0);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
